// File: rtl/adc_axis_stream_buffered.sv
// ADC sample capture into an FWFT FIFO feeding an AXI4-Stream master.
// A full FIFO drops samples and counts them; disabling the stream drains the FIFO and closes the packet with TLAST.
module adc_axis_stream_buffered #(
  parameter int ADC_WIDTH            = 14,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int PKT_LEN_WIDTH        = 16,
  parameter int START_COUNT          = 32
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESET,
  input  logic [ADC_WIDTH:0]                ADCdata,
  input  logic                              streamEnable,
  input  logic [PKT_LEN_WIDTH-1:0]          pktLen,
  input  logic                              signExtend,
  input  logic                              testMode,
  input  logic                              clearOverRun,
  input  logic                              clearOTR,
  output logic                              streamStatus,
  output logic                              overRunStatus,
  output logic [15:0]                       overRunCount,
  output logic                              adcOTRstatus,
  output logic [$clog2(FIFO_DEPTH):0]       fifoLevel,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int DW = C_M_AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {STARTUP, IDLE, STREAM, DRAIN} state_t;
  state_t state, stateNext;

  logic [ADC_WIDTH:0]     adcReg;
  logic                   testModeReg, signExtendReg;
  logic [7:0]             startCnt;
  logic [PKT_LEN_WIDTH-1:0] pktLenReg, pktCnt;
  logic [DW-1:0]          testCnt, sampleWord, wordReg;
  logic                   wrVld;
  logic [DW-1:0]          mem [FIFO_DEPTH];
  logic [LW-1:0]          wrPtr, rdPtr;
  logic [LW:0]            level;
  logic                   full, empty, push, pop, drop, lastWord;
  logic                   captureEn, streamStart, enterIdle, inStream, inDrain;

  // pin capture
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      adcReg        <= '0;
      testModeReg   <= 1'b0;
      signExtendReg <= 1'b0;
    end else begin
      adcReg        <= ADCdata;
      testModeReg   <= testMode;
      signExtendReg <= signExtend;
    end
  end

  // FSM: state register / next state / outputs
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) state <= STARTUP;
    else               state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      STARTUP: if (startCnt == 8'(START_COUNT)) stateNext = IDLE;
      IDLE:    if (streamEnable && empty)       stateNext = STREAM;
      STREAM:  if (!streamEnable)               stateNext = DRAIN;
      DRAIN:   if (empty)                       stateNext = IDLE;
      default:                                  stateNext = STARTUP;
    endcase
  end

  always_comb begin
    inStream    = (state == STREAM);
    inDrain     = (state == DRAIN);
    captureEn   = inStream && streamEnable;
    streamStart = (state == IDLE) && (stateNext == STREAM);
    enterIdle   = (state != IDLE) && (stateNext == IDLE);
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET)                                     startCnt <= '0;
    else if (state == STARTUP && startCnt != 8'(START_COUNT)) startCnt <= startCnt + 8'd1;
  end

  // sample word formatting; the OTR bit never reaches TDATA
  always_comb begin
    sampleWord = '0;
    if (testModeReg) sampleWord = testCnt;
    else begin
      sampleWord[ADC_WIDTH-1:0] = adcReg[ADC_WIDTH-1:0];
      if (signExtendReg && adcReg[ADC_WIDTH-1]) sampleWord[DW-1:ADC_WIDTH] = '1;
    end
  end

  // write stage: test counter advances on every capture, dropped or not
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      wrVld   <= 1'b0;
      wordReg <= '0;
      testCnt <= '0;
    end else begin
      wrVld <= captureEn;
      if (captureEn) begin
        wordReg <= sampleWord;
        testCnt <= testCnt + DW'(1);
      end else if (streamStart) begin
        testCnt <= '0;
      end
    end
  end

  // FWFT FIFO; a full FIFO rejects the write even if it pops that cycle
  assign full  = (level == (LW+1)'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign push  = wrVld && !full;
  assign drop  = wrVld && full;
  assign pop   = !empty && M_AXIS_TREADY;

  always_ff @(posedge M_AXIS_ACLK) begin
    if (push) mem[wrPtr] <= wordReg;
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + LW'(1);
      if (pop)  rdPtr <= rdPtr + LW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (LW+1)'(1);
        2'b01:   level <= level - (LW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // pktLenReg-1 wraps to all ones, so pktLen 0 gives 2^PKT_LEN_WIDTH words
  assign lastWord = !empty &&
                    ((pktCnt == pktLenReg - PKT_LEN_WIDTH'(1)) ||
                     (inDrain && level == (LW+1)'(1)));

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      pktLenReg <= '0;
      pktCnt    <= '0;
    end else if (streamStart) begin
      pktLenReg <= pktLen;
      pktCnt    <= '0;
    end else if (pop) begin
      pktCnt <= lastWord ? '0 : pktCnt + PKT_LEN_WIDTH'(1);
    end
  end

  // status flags; clears win over simultaneous sets
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      streamStatus  <= 1'b0;
      overRunStatus <= 1'b0;
      overRunCount  <= '0;
      adcOTRstatus  <= 1'b0;
    end else begin
      if (enterIdle) streamStatus <= 1'b0;
      else if (pop)  streamStatus <= 1'b1;

      if (clearOverRun) begin
        overRunStatus <= 1'b0;
        overRunCount  <= '0;
      end else if (drop) begin
        overRunStatus <= 1'b1;
        if (overRunCount != 16'hFFFF) overRunCount <= overRunCount + 16'd1;
      end

      if (clearOTR)                       adcOTRstatus <= 1'b0;
      else if (inStream && adcReg[ADC_WIDTH]) adcOTRstatus <= 1'b1;
    end
  end

  assign fifoLevel     = level;
  assign M_AXIS_TVALID = !empty;
  assign M_AXIS_TDATA  = empty ? '0 : mem[rdPtr];
  assign M_AXIS_TLAST  = lastWord;
  assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_adc_axis_stream_buffered.sv
// Directed bench for adc_axis_stream_buffered: startup, streaming, formatting, stalls/overrun, drain, packet length, reset.
module tb_adc_axis_stream_buffered;
  localparam int AW = 14, DW = 32, FD = 16, PW = 4, SC = 32;

  logic            M_AXIS_ACLK = 1'b0;
  logic            M_AXIS_ARESET;
  logic [AW:0]     ADCdata;
  logic            streamEnable, signExtend, testMode, clearOverRun, clearOTR;
  logic [PW-1:0]   pktLen;
  logic            streamStatus, overRunStatus, adcOTRstatus;
  logic [15:0]     overRunCount;
  logic [$clog2(FD):0] fifoLevel;
  logic            M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic [DW-1:0]   M_AXIS_TDATA;
  logic [DW/8-1:0] M_AXIS_TSTRB;

  always #5 M_AXIS_ACLK = ~M_AXIS_ACLK;

  adc_axis_stream_buffered #(
    .ADC_WIDTH(AW), .C_M_AXIS_TDATA_WIDTH(DW), .FIFO_DEPTH(FD),
    .PKT_LEN_WIDTH(PW), .START_COUNT(SC)
  ) dut (
    .M_AXIS_ACLK(M_AXIS_ACLK), .M_AXIS_ARESET(M_AXIS_ARESET), .ADCdata(ADCdata),
    .streamEnable(streamEnable), .pktLen(pktLen), .signExtend(signExtend),
    .testMode(testMode), .clearOverRun(clearOverRun), .clearOTR(clearOTR),
    .streamStatus(streamStatus), .overRunStatus(overRunStatus),
    .overRunCount(overRunCount), .adcOTRstatus(adcOTRstatus), .fifoLevel(fifoLevel),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  int nAssert = 0, nFail = 0;
  logic [DW-1:0] qData[$];
  logic          qLast[$];

  // record the handshake that the coming edge completes, then step past it
  task automatic cyc();
    if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      qData.push_back(M_AXIS_TDATA);
      qLast.push_back(M_AXIS_TLAST);
    end
    @(posedge M_AXIS_ACLK);
    #1;
  endtask

  task automatic cycN(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clrQ();
    qData.delete();
    qLast.delete();
  endtask

  task automatic chkOutputsIdle(input string tag);
    chk({tag, "_tvalid"}, 64'(M_AXIS_TVALID), 64'(0));
    chk({tag, "_tlast"},  64'(M_AXIS_TLAST),  64'(0));
    chk({tag, "_tdata"},  64'(M_AXIS_TDATA),  64'(0));
    chk({tag, "_level"},  64'(fifoLevel),     64'(0));
    chk({tag, "_sstat"},  64'(streamStatus),  64'(0));
    chk({tag, "_ovr"},    64'(overRunStatus), 64'(0));
    chk({tag, "_ovrcnt"}, 64'(overRunCount),  64'(0));
    chk({tag, "_otr"},    64'(adcOTRstatus),  64'(0));
  endtask

  initial begin
    int n, peak;
    M_AXIS_ARESET = 1'b1; streamEnable = 1'b0; pktLen = 4'd8; signExtend = 1'b0;
    testMode = 1'b1; clearOverRun = 1'b0; clearOTR = 1'b0; ADCdata = '0; M_AXIS_TREADY = 1'b1;
    cycN(3);
    chkOutputsIdle("reset");
    chk("reset_tstrb", 64'(M_AXIS_TSTRB), 64'hF);
    M_AXIS_ARESET = 1'b0;
    cycN(SC + 2);
    chk("startup_tvalid", 64'(M_AXIS_TVALID), 64'(0));

    // contiguous test-counter stream, pktLen 8
    streamEnable = 1'b1;
    cyc();
    cyc();
    chk("lat_tvalid_early", 64'(M_AXIS_TVALID), 64'(0));
    cyc();
    chk("lat_tvalid", 64'(M_AXIS_TVALID), 64'(1));
    chk("lat_tdata0", 64'(M_AXIS_TDATA), 64'(0));
    n = 0;
    while (qData.size() < 24 && n < 100) begin cyc(); n++; end
    chk("s1_count", 64'(qData.size()), 64'(24));
    for (int i = 0; i < qData.size(); i++) begin
      chk($sformatf("s1_data%0d", i), 64'(qData[i]), 64'(i));
      chk($sformatf("s1_last%0d", i), 64'(qLast[i]), 64'(i % 8 == 7));
    end
    chk("s1_sstat", 64'(streamStatus), 64'(1));
    chk("s1_ovrcnt", 64'(overRunCount), 64'(0));

    // ADC formatting, latency and OTR
    testMode = 1'b0; signExtend = 1'b1; ADCdata = 15'h2000;
    cycN(5);
    chk("sext", 64'(M_AXIS_TDATA), 64'hFFFFE000);
    signExtend = 1'b0;
    cycN(5);
    chk("zext", 64'(M_AXIS_TDATA), 64'h00002000);
    ADCdata = 15'h0123;
    cycN(2);
    chk("adc_lat2", 64'(M_AXIS_TDATA), 64'h2000);
    cyc();
    chk("adc_lat3", 64'(M_AXIS_TDATA), 64'h0123);
    chk("otr_clear_before", 64'(adcOTRstatus), 64'(0));
    ADCdata = 15'h6000;
    cycN(3);
    chk("otr_set", 64'(adcOTRstatus), 64'(1));
    ADCdata = 15'h2000;
    cycN(3);
    chk("otr_sticky", 64'(adcOTRstatus), 64'(1));
    clearOTR = 1'b1;
    cyc();
    clearOTR = 1'b0;
    cyc();
    chk("otr_cleared", 64'(adcOTRstatus), 64'(0));

    ADCdata = '0; testMode = 1'b1; streamEnable = 1'b0;
    cycN(20);
    chk("s1end_tvalid", 64'(M_AXIS_TVALID), 64'(0));
    chk("s1end_level", 64'(fifoLevel), 64'(0));
    chk("s1end_sstat", 64'(streamStatus), 64'(0));

    // drain: five words queued under backpressure, then disable
    clrQ();
    M_AXIS_TREADY = 1'b0; streamEnable = 1'b1;
    cyc();
    cycN(5);
    streamEnable = 1'b0;
    cyc();
    chk("drain_level5", 64'(fifoLevel), 64'(5));
    chk("drain_tvalid", 64'(M_AXIS_TVALID), 64'(1));
    chk("drain_head", 64'(M_AXIS_TDATA), 64'(0));
    for (int i = 0; i < 12; i++) begin
      M_AXIS_TREADY = (i % 2 == 0);
      cyc();
    end
    M_AXIS_TREADY = 1'b1;
    cycN(6);
    chk("drain_count", 64'(qData.size()), 64'(5));
    for (int i = 0; i < qData.size(); i++) begin
      chk($sformatf("drain_data%0d", i), 64'(qData[i]), 64'(i));
      chk($sformatf("drain_last%0d", i), 64'(qLast[i]), 64'(i == 4));
    end
    chk("drain_end_tvalid", 64'(M_AXIS_TVALID), 64'(0));
    chk("drain_end_level", 64'(fifoLevel), 64'(0));
    chk("drain_end_sstat", 64'(streamStatus), 64'(0));

    // 10-cycle stall: level 1 grows to 11, nothing lost, counter restarts at 0
    clrQ();
    streamEnable = 1'b1;
    cyc();
    cycN(10);
    M_AXIS_TREADY = 1'b0;
    peak = 0;
    repeat (10) begin
      cyc();
      if (int'(fifoLevel) > peak) peak = int'(fifoLevel);
    end
    chk("stall10_peak", 64'(peak), 64'(11));
    M_AXIS_TREADY = 1'b1;
    cycN(10);
    streamEnable = 1'b0;
    cycN(20);
    chk("stall10_count", 64'(qData.size()), 64'(30));
    for (int i = 0; i < qData.size(); i++)
      chk($sformatf("stall10_data%0d", i), 64'(qData[i]), 64'(i));
    chk("stall10_ovr", 64'(overRunStatus), 64'(0));
    chk("stall10_ovrcnt", 64'(overRunCount), 64'(0));

    // 30-cycle stall from level 1: 15 fit, 15 drop, plus one drop on the full-with-pop edge
    clrQ();
    streamEnable = 1'b1;
    cyc();
    cycN(10);
    M_AXIS_TREADY = 1'b0;
    cycN(30);
    chk("stall30_level", 64'(fifoLevel), 64'(16));
    chk("stall30_ovrcnt", 64'(overRunCount), 64'(15));
    chk("stall30_ovr", 64'(overRunStatus), 64'(1));
    M_AXIS_TREADY = 1'b1; clearOverRun = 1'b1;
    cyc();
    clearOverRun = 1'b0;
    chk("clrovr_cnt", 64'(overRunCount), 64'(0));
    chk("clrovr_flag", 64'(overRunStatus), 64'(0));
    cycN(9);
    chk("clrovr_hold", 64'(overRunCount), 64'(0));
    streamEnable = 1'b0;
    cycN(25);
    chk("stall30_count", 64'(qData.size()), 64'(34));
    for (int i = 0; i < qData.size(); i++)
      chk($sformatf("stall30_data%0d", i), 64'(qData[i]), 64'((i < 24) ? i : i + 16));

    // pktLen 0 -> 16-word packets; mid-stream pktLen change ignored
    clrQ();
    pktLen = 4'd0; ADCdata = 15'h4000; streamEnable = 1'b1;
    cyc();
    cycN(5);
    pktLen = 4'd5;
    n = 0;
    while (qData.size() < 40 && n < 100) begin cyc(); n++; end
    chk("pkt16_count", 64'(qData.size()), 64'(40));
    for (int i = 0; i < qData.size(); i++) begin
      chk($sformatf("pkt16_data%0d", i), 64'(qData[i]), 64'(i));
      chk($sformatf("pkt16_last%0d", i), 64'(qLast[i]), 64'(i % 16 == 15));
    end

    // fill with overrun and OTR, then reset mid-packet
    M_AXIS_TREADY = 1'b0;
    cycN(20);
    chk("prerst_ovr", 64'(overRunStatus), 64'(1));
    chk("prerst_ovrcnt", 64'(overRunCount), 64'(5));
    chk("prerst_otr", 64'(adcOTRstatus), 64'(1));
    chk("prerst_tvalid", 64'(M_AXIS_TVALID), 64'(1));
    M_AXIS_ARESET = 1'b1;
    cyc();
    chkOutputsIdle("midrst");
    M_AXIS_ARESET = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
